// File: rtl/prog_loader_imem.sv
// Instruction memory with a built-in streaming program loader. The loader optionally
// pre-fills the array with NOP_WORD, writes a counted word stream from a base address,
// and keeps the core held until that load has finished.
module prog_loader_imem #(
    parameter int                DATA_W         = 32,
    parameter int                DEPTH          = 256,
    parameter int                ADDR_W         = 8,
    parameter logic [DATA_W-1:0] NOP_WORD       = 32'h68000000,
    parameter bit                CLEAR_ON_START = 1'b1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              ld_start_i,
    input  logic [ADDR_W-1:0] ld_base_i,
    input  logic [ADDR_W:0]   ld_count_i,
    input  logic              ld_valid_i,
    input  logic [DATA_W-1:0] ld_data_i,
    output logic              ld_ready_o,
    output logic              ld_busy_o,
    output logic              ld_done_o,
    output logic              ld_err_o,
    output logic              core_hold_o,
    input  logic              fetch_en_i,
    input  logic [ADDR_W-1:0] fetch_addr_i,
    output logic [DATA_W-1:0] fetch_data_o
);

    // state | meaning
    // IDLE  | out of reset, no program loaded yet, core held
    // CLEAR | writing NOP_WORD to every address, one per cycle
    // LOAD  | accepting stream words; done pulses once remaining hits zero
    // DONE  | program loaded, core released, waiting for another ld_start
    typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_LOAD, S_DONE} state_e;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   REM_ZERO  = '0;
    localparam logic [ADDR_W:0]   REM_ONE   = (ADDR_W + 1)'(1);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   ptr_q, ptr_d;
    logic [ADDR_W:0]     rem_q, rem_d;
    logic [ADDR_W-1:0]   clr_q, clr_d;
    logic                err_q, err_d;
    logic                ready_q, busy_q, done_q, hold_q;
    logic [DATA_W-1:0]   fetch_q;

    logic                we;
    logic [ADDR_W-1:0]   waddr;
    logic [DATA_W-1:0]   wdata;

    logic [DATA_W-1:0]   mem [DEPTH];

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        rem_d   = rem_q;
        clr_d   = clr_q;
        err_d   = err_q;
        we      = 1'b0;
        waddr   = ptr_q;
        wdata   = ld_data_i;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (ld_start_i) begin
                    ptr_d   = ld_base_i;
                    rem_d   = ld_count_i;
                    clr_d   = '0;
                    err_d   = 1'b0;
                    state_d = CLEAR_ON_START ? S_CLEAR : S_LOAD;
                end
            end
            S_CLEAR: begin
                we    = 1'b1;
                waddr = clr_q;
                wdata = NOP_WORD;
                clr_d = clr_q + 1'b1;
                if (clr_q == LAST_ADDR) state_d = S_LOAD;
            end
            S_LOAD: begin
                if (rem_q == REM_ZERO) begin
                    state_d = S_DONE;
                end else if (ld_valid_i) begin
                    we    = 1'b1;
                    ptr_d = ptr_q + 1'b1;
                    rem_d = rem_q - 1'b1;
                    // Only a write at the top address with more words still to come wraps.
                    if (ptr_q == LAST_ADDR && rem_q != REM_ONE) err_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            rem_q   <= '0;
            clr_q   <= '0;
            err_q   <= 1'b0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            hold_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            rem_q   <= rem_d;
            clr_q   <= clr_d;
            err_q   <= err_d;
            ready_q <= (state_d == S_LOAD) && (rem_d != REM_ZERO);
            busy_q  <= (state_d == S_CLEAR) || (state_d == S_LOAD);
            done_q  <= (state_d == S_LOAD) && (rem_d == REM_ZERO);
            hold_q  <= (state_d != S_DONE);
        end
    end

    always_ff @(posedge clk_i) begin
        if (we) mem[waddr] <= wdata;
    end

    // Nonblocking read gives read-before-write against a same-cycle loader write.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fetch_q <= NOP_WORD;
        end else if (hold_q) begin
            fetch_q <= NOP_WORD;
        end else if (fetch_en_i) begin
            fetch_q <= mem[fetch_addr_i];
        end
    end

    assign ld_ready_o   = ready_q;
    assign ld_busy_o    = busy_q;
    assign ld_done_o    = done_q;
    assign ld_err_o     = err_q;
    assign core_hold_o  = hold_q;
    assign fetch_data_o = fetch_q;

endmodule

// File: tb/tb_prog_loader_imem.sv
// Bench for prog_loader_imem: a 256-word instance without pre-fill and a 16-word
// instance with pre-fill, checked against an address-indexed memory model.
module tb_prog_loader_imem;
    localparam logic [31:0] NOP = 32'h68000000;

    logic clk, rst_n;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic        a_ld_start, a_ld_valid, a_ld_ready, a_ld_busy, a_ld_done, a_ld_err, a_core_hold, a_fetch_en;
    logic [7:0]  a_ld_base, a_fetch_addr;
    logic [8:0]  a_ld_count;
    logic [31:0] a_ld_data, a_fetch_data;

    logic        b_ld_start, b_ld_valid, b_ld_ready, b_ld_busy, b_ld_done, b_ld_err, b_core_hold, b_fetch_en;
    logic [3:0]  b_ld_base, b_fetch_addr;
    logic [4:0]  b_ld_count;
    logic [31:0] b_ld_data, b_fetch_data;

    prog_loader_imem #(.DATA_W(32), .DEPTH(256), .ADDR_W(8), .NOP_WORD(NOP), .CLEAR_ON_START(1'b0)) dut_a (
        .clk_i(clk), .rst_ni(rst_n), .ld_start_i(a_ld_start), .ld_base_i(a_ld_base), .ld_count_i(a_ld_count),
        .ld_valid_i(a_ld_valid), .ld_data_i(a_ld_data), .ld_ready_o(a_ld_ready), .ld_busy_o(a_ld_busy),
        .ld_done_o(a_ld_done), .ld_err_o(a_ld_err), .core_hold_o(a_core_hold), .fetch_en_i(a_fetch_en),
        .fetch_addr_i(a_fetch_addr), .fetch_data_o(a_fetch_data));

    prog_loader_imem #(.DATA_W(32), .DEPTH(16), .ADDR_W(4), .NOP_WORD(NOP), .CLEAR_ON_START(1'b1)) dut_b (
        .clk_i(clk), .rst_ni(rst_n), .ld_start_i(b_ld_start), .ld_base_i(b_ld_base), .ld_count_i(b_ld_count),
        .ld_valid_i(b_ld_valid), .ld_data_i(b_ld_data), .ld_ready_o(b_ld_ready), .ld_busy_o(b_ld_busy),
        .ld_done_o(b_ld_done), .ld_err_o(b_ld_err), .core_hold_o(b_core_hold), .fetch_en_i(b_fetch_en),
        .fetch_addr_i(b_fetch_addr), .fetch_data_o(b_fetch_data));

    int total, bad;
    logic [31:0] stim[$];
    logic [31:0] ref_mem [256];
    bit          ref_wr  [256];

    int n_acc, n_done, done_cyc, done_at, busy_bad;
    int bn_acc, bn_done, bn_busy, bn_ready_early;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic void ref_load(input int base, input int cnt);
        for (int i = 0; i < cnt; i++) begin
            ref_mem[(base + i) % 256] = stim[i];
            ref_wr[(base + i) % 256]  = 1'b1;
        end
    endfunction

    function automatic void rand_stim(input int n);
        stim.delete();
        for (int i = 0; i < n; i++) stim.push_back($urandom);
    endfunction

    // vmode: 0 = valid held high, 1 = pattern 1,0,0, 2 = random; poke re-pulses ld_start mid-load
    task automatic run_load_a(input int base, input int cnt, input int vmode, input bit poke);
        int acc;
        acc = 0; n_done = 0; done_cyc = -1; done_at = -1; busy_bad = 0;
        a_ld_base = 8'(base); a_ld_count = 9'(cnt); a_ld_start = 1'b1;
        tick();
        a_ld_start = 1'b0; a_ld_base = ~8'(base); a_ld_count = 9'd3;
        for (int cyc = 0; cyc < 2000 && n_done == 0; cyc++) begin
            a_ld_valid = (vmode == 0) ? 1'b1 : (vmode == 1) ? (cyc % 3 == 0) : 1'($urandom_range(0, 1));
            a_ld_data  = (acc < stim.size()) ? stim[acc] : $urandom;
            if (poke && cyc == 2) begin
                a_ld_start = 1'b1; a_ld_base = 8'h33; a_ld_count = 9'd5;
            end else begin
                a_ld_start = 1'b0;
            end
            #2;
            if (a_ld_done) begin n_done++; done_cyc = cyc; done_at = acc; end
            if (!a_ld_busy || !a_core_hold) busy_bad++;
            if (a_ld_valid && a_ld_ready) acc++;
            tick();
        end
        a_ld_valid = 1'b0; a_ld_start = 1'b0;
        n_acc = acc;
    endtask

    task automatic run_load_b(input int base, input int cnt);
        bn_acc = 0; bn_done = 0; bn_busy = 0; bn_ready_early = 0;
        b_ld_base = 4'(base); b_ld_count = 5'(cnt); b_ld_start = 1'b1;
        tick();
        b_ld_start = 1'b0;
        for (int cyc = 0; cyc < 200 && bn_done == 0; cyc++) begin
            b_ld_valid = 1'b1;
            b_ld_data  = (bn_acc < stim.size()) ? stim[bn_acc] : 32'hDEAD0000;
            #2;
            if (b_ld_busy) bn_busy++;
            if (b_ld_ready && cyc < 16) bn_ready_early++;
            if (b_ld_done) bn_done++;
            if (b_ld_valid && b_ld_ready) bn_acc++;
            tick();
        end
        b_ld_valid = 1'b0;
    endtask

    task automatic fetch_a(input int addr, output logic [31:0] d);
        a_fetch_en = 1'b1; a_fetch_addr = 8'(addr);
        tick();
        d = a_fetch_data; a_fetch_en = 1'b0;
    endtask

    task automatic fetch_b(input int addr, output logic [31:0] d);
        b_fetch_en = 1'b1; b_fetch_addr = 4'(addr);
        tick();
        d = b_fetch_data; b_fetch_en = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        rst_n = 1'b0;
        repeat (2) tick();
        total++; if (a_ld_ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b exp=0", a_ld_ready); end
        total++; if (a_ld_busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", a_ld_busy); end
        total++; if (a_ld_done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", a_ld_done); end
        total++; if (a_ld_err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", a_ld_err); end
        total++; if (a_core_hold !== 1'b1) begin bad++; $display("FAIL reset_hold got=%b exp=1", a_core_hold); end
        total++; if (a_fetch_data !== NOP) begin bad++; $display("FAIL reset_fetch got=%h exp=%h", a_fetch_data, NOP); end
        total++; if (b_core_hold !== 1'b1) begin bad++; $display("FAIL reset_hold_b got=%b exp=1", b_core_hold); end
        rst_n = 1'b1;
        tick();
        fetch_a(0, d);
        total++; if (d !== NOP) begin bad++; $display("FAIL idle_fetch_held got=%h exp=%h", d, NOP); end
        total++; if (a_core_hold !== 1'b1) begin bad++; $display("FAIL idle_hold got=%b exp=1", a_core_hold); end
    endtask

    task automatic test_basic();
        logic [31:0] d;
        logic [31:0] exp_w [4];
        int          addrs [4];
        stim = '{32'h4C40001F, 32'h4C80001D, 32'h68000000, 32'h68000000, 32'h68000000,
                 32'h10C48000, 32'h68000000, 32'h68000000, 32'h68000000, 32'h0D0C0032};
        exp_w = '{32'h4C40001F, 32'h4C80001D, 32'h10C48000, 32'h0D0C0032};
        addrs = '{0, 1, 5, 9};
        run_load_a(0, 10, 0, 1'b0);
        ref_load(0, 10);
        total++; if (n_acc !== 10) begin bad++; $display("FAIL basic_accepts got=%0d exp=10", n_acc); end
        total++; if (n_done !== 1) begin bad++; $display("FAIL basic_done_pulses got=%0d exp=1", n_done); end
        total++; if (done_cyc !== 10) begin bad++; $display("FAIL basic_done_cycle got=%0d exp=10", done_cyc); end
        total++; if (busy_bad !== 0) begin bad++; $display("FAIL basic_busy_hold got=%0d exp=0", busy_bad); end
        total++; if (a_core_hold !== 1'b0) begin bad++; $display("FAIL basic_hold_after got=%b exp=0", a_core_hold); end
        total++; if (a_ld_busy !== 1'b0) begin bad++; $display("FAIL basic_busy_after got=%b exp=0", a_ld_busy); end
        total++; if (a_ld_done !== 1'b0) begin bad++; $display("FAIL basic_done_after got=%b exp=0", a_ld_done); end
        total++; if (a_ld_err !== 1'b0) begin bad++; $display("FAIL basic_err got=%b exp=0", a_ld_err); end
        for (int i = 0; i < 4; i++) begin
            fetch_a(addrs[i], d);
            total++; if (d !== exp_w[i]) begin bad++; $display("FAIL basic_fetch addr=%0d got=%h exp=%h", addrs[i], d, exp_w[i]); end
        end
        a_fetch_addr = 8'd1;
        tick();
        total++; if (a_fetch_data !== 32'h0D0C0032) begin bad++; $display("FAIL fetch_hold_no_en got=%h exp=0d0c0032", a_fetch_data); end
    endtask

    task automatic test_backpressure();
        logic [31:0] d;
        rand_stim(10);
        run_load_a(0, 10, 1, 1'b0);
        ref_load(0, 10);
        total++; if (n_acc !== 10) begin bad++; $display("FAIL bp_accepts got=%0d exp=10", n_acc); end
        total++; if (n_done !== 1) begin bad++; $display("FAIL bp_done_pulses got=%0d exp=1", n_done); end
        total++; if (done_at !== 10) begin bad++; $display("FAIL bp_done_after_accepts got=%0d exp=10", done_at); end
        total++; if (done_cyc !== 28) begin bad++; $display("FAIL bp_done_cycle got=%0d exp=28", done_cyc); end
        for (int i = 0; i < 10; i++) begin
            fetch_a(i, d);
            total++; if (d !== ref_mem[i]) begin bad++; $display("FAIL bp_fetch addr=%0d got=%h exp=%h", i, d, ref_mem[i]); end
        end
    endtask

    task automatic test_wrap();
        logic [31:0] d;
        int addrs [4];
        stim = '{32'd1, 32'd2, 32'd3, 32'd4};
        addrs = '{254, 255, 0, 1};
        run_load_a(254, 4, 0, 1'b0);
        ref_load(254, 4);
        total++; if (n_acc !== 4) begin bad++; $display("FAIL wrap_accepts got=%0d exp=4", n_acc); end
        total++; if (a_ld_err !== 1'b1) begin bad++; $display("FAIL wrap_err got=%b exp=1", a_ld_err); end
        for (int i = 0; i < 4; i++) begin
            fetch_a(addrs[i], d);
            total++; if (d !== 32'(i + 1)) begin bad++; $display("FAIL wrap_fetch addr=%0d got=%h exp=%h", addrs[i], d, i + 1); end
        end
        total++; if (a_ld_err !== 1'b1) begin bad++; $display("FAIL wrap_err_sticky got=%b exp=1", a_ld_err); end
    endtask

    task automatic test_count_zero();
        logic [31:0] d;
        run_load_a(7, 0, 0, 1'b0);
        total++; if (n_done !== 1) begin bad++; $display("FAIL zero_done_pulses got=%0d exp=1", n_done); end
        total++; if (done_cyc !== 0) begin bad++; $display("FAIL zero_done_cycle got=%0d exp=0", done_cyc); end
        total++; if (n_acc !== 0) begin bad++; $display("FAIL zero_accepts got=%0d exp=0", n_acc); end
        total++; if (a_ld_err !== 1'b0) begin bad++; $display("FAIL zero_err_cleared got=%b exp=0", a_ld_err); end
        fetch_a(0, d);
        total++; if (d !== ref_mem[0]) begin bad++; $display("FAIL zero_mem_kept got=%h exp=%h", d, ref_mem[0]); end
    endtask

    task automatic test_mid_start();
        logic [31:0] d;
        rand_stim(10);
        run_load_a(8'h80, 10, 1, 1'b1);
        ref_load(8'h80, 10);
        total++; if (n_acc !== 10) begin bad++; $display("FAIL midstart_accepts got=%0d exp=10", n_acc); end
        total++; if (done_cyc !== 28) begin bad++; $display("FAIL midstart_done_cycle got=%0d exp=28", done_cyc); end
        for (int i = 0; i < 10; i++) begin
            fetch_a(8'h80 + i, d);
            total++; if (d !== ref_mem[8'h80 + i]) begin bad++; $display("FAIL midstart_fetch addr=%0d got=%h exp=%h", 8'h80 + i, d, ref_mem[8'h80 + i]); end
        end
    endtask

    task automatic test_random();
        logic [31:0] d;
        int base, cnt, a;
        for (int it = 0; it < 6; it++) begin
            base = $urandom_range(0, 255);
            cnt  = $urandom_range(1, 40);
            rand_stim(cnt);
            run_load_a(base, cnt, 2, 1'b0);
            ref_load(base, cnt);
            total++; if (n_acc !== cnt) begin bad++; $display("FAIL rnd_accepts got=%0d exp=%0d", n_acc, cnt); end
            total++; if (n_done !== 1) begin bad++; $display("FAIL rnd_done_pulses got=%0d exp=1", n_done); end
            total++; if (a_ld_err !== (base + cnt > 256)) begin bad++; $display("FAIL rnd_err base=%0d cnt=%0d got=%b", base, cnt, a_ld_err); end
            for (int i = 0; i < cnt; i++) begin
                a = (base + i) % 256;
                fetch_a(a, d);
                total++; if (d !== ref_mem[a]) begin bad++; $display("FAIL rnd_fetch addr=%0d got=%h exp=%h", a, d, ref_mem[a]); end
            end
        end
    endtask

    task automatic test_full();
        logic [31:0] d;
        int a;
        rand_stim(256);
        run_load_a(0, 256, 0, 1'b0);
        ref_load(0, 256);
        total++; if (n_acc !== 256) begin bad++; $display("FAIL full_accepts got=%0d exp=256", n_acc); end
        total++; if (done_cyc !== 256) begin bad++; $display("FAIL full_done_cycle got=%0d exp=256", done_cyc); end
        total++; if (a_ld_err !== 1'b0) begin bad++; $display("FAIL full_base0_err got=%b exp=0", a_ld_err); end
        rand_stim(256);
        run_load_a(5, 256, 0, 1'b0);
        ref_load(5, 256);
        total++; if (a_ld_err !== 1'b1) begin bad++; $display("FAIL full_base5_err got=%b exp=1", a_ld_err); end
        for (int i = 0; i < 12; i++) begin
            a = (i < 2) ? i + 4 : $urandom_range(0, 255);
            fetch_a(a, d);
            total++; if (d !== ref_mem[a]) begin bad++; $display("FAIL full_fetch addr=%0d got=%h exp=%h", a, d, ref_mem[a]); end
        end
    endtask

    task automatic test_clear();
        logic [31:0] d;
        int nop_addrs [4];
        nop_addrs = '{0, 3, 6, 15};
        rand_stim(16);
        run_load_b(0, 16);
        total++; if (bn_acc !== 16) begin bad++; $display("FAIL clr_prefill_accepts got=%0d exp=16", bn_acc); end
        total++; if (bn_busy !== 33) begin bad++; $display("FAIL clr_prefill_busy got=%0d exp=33", bn_busy); end
        stim = '{32'hAAAA0001, 32'hAAAA0002};
        run_load_b(4, 2);
        total++; if (bn_busy !== 19) begin bad++; $display("FAIL clr_busy_cycles got=%0d exp=19", bn_busy); end
        total++; if (bn_ready_early !== 0) begin bad++; $display("FAIL clr_ready_in_clear got=%0d exp=0", bn_ready_early); end
        total++; if (bn_acc !== 2) begin bad++; $display("FAIL clr_accepts got=%0d exp=2", bn_acc); end
        total++; if (bn_done !== 1) begin bad++; $display("FAIL clr_done_pulses got=%0d exp=1", bn_done); end
        total++; if (b_core_hold !== 1'b0) begin bad++; $display("FAIL clr_hold_after got=%b exp=0", b_core_hold); end
        fetch_b(4, d);
        total++; if (d !== 32'hAAAA0001) begin bad++; $display("FAIL clr_fetch4 got=%h exp=aaaa0001", d); end
        fetch_b(5, d);
        total++; if (d !== 32'hAAAA0002) begin bad++; $display("FAIL clr_fetch5 got=%h exp=aaaa0002", d); end
        for (int i = 0; i < 4; i++) begin
            fetch_b(nop_addrs[i], d);
            total++; if (d !== NOP) begin bad++; $display("FAIL clr_fetch_nop addr=%0d got=%h exp=%h", nop_addrs[i], d, NOP); end
        end
    endtask

    task automatic test_reset_mid_load();
        logic [31:0] d;
        rand_stim(10);
        a_ld_base = 8'h10; a_ld_count = 9'd10; a_ld_start = 1'b1;
        tick();
        a_ld_start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            a_ld_valid = 1'b1; a_ld_data = stim[i];
            tick();
        end
        a_ld_valid = 1'b0;
        ref_load(8'h10, 3);
        #2 rst_n = 1'b0;
        #1;
        total++; if (a_ld_busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy got=%b exp=0", a_ld_busy); end
        total++; if (a_ld_ready !== 1'b0) begin bad++; $display("FAIL rstmid_ready got=%b exp=0", a_ld_ready); end
        total++; if (a_core_hold !== 1'b1) begin bad++; $display("FAIL rstmid_hold got=%b exp=1", a_core_hold); end
        total++; if (a_fetch_data !== NOP) begin bad++; $display("FAIL rstmid_fetch got=%h exp=%h", a_fetch_data, NOP); end
        tick();
        rst_n = 1'b1;
        tick();
        fetch_a(8'h10, d);
        total++; if (d !== NOP) begin bad++; $display("FAIL rstmid_fetch_held got=%h exp=%h", d, NOP); end
        stim.delete();
        run_load_a(8'h50, 0, 0, 1'b0);
        total++; if (n_done !== 1) begin bad++; $display("FAIL rstmid_reload_done got=%0d exp=1", n_done); end
        for (int i = 0; i < 4; i++) begin
            fetch_a(8'h10 + i, d);
            total++; if (d !== ref_mem[8'h10 + i]) begin bad++; $display("FAIL rstmid_partial addr=%0d got=%h exp=%h", 8'h10 + i, d, ref_mem[8'h10 + i]); end
        end
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        total = 0; bad = 0;
        rst_n = 1'b0;
        a_ld_start = 1'b0; a_ld_valid = 1'b0; a_ld_base = '0; a_ld_count = '0; a_ld_data = '0;
        a_fetch_en = 1'b0; a_fetch_addr = '0;
        b_ld_start = 1'b0; b_ld_valid = 1'b0; b_ld_base = '0; b_ld_count = '0; b_ld_data = '0;
        b_fetch_en = 1'b0; b_fetch_addr = '0;
        for (int i = 0; i < 256; i++) begin ref_mem[i] = 'x; ref_wr[i] = 1'b0; end
        test_reset();
        test_basic();
        test_backpressure();
        test_wrap();
        test_count_zero();
        test_mid_start();
        test_random();
        test_full();
        test_clear();
        test_reset_mid_load();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
